// File: rtl/sprite_fetch_pkg.sv
// sprite_fetch_pkg: shared phase/state types, temp-RAM byte offsets and load-strobe indices
// for the sprite pattern fetch sequencer.
package sprite_fetch_pkg;

  typedef enum logic [2:0] {
    P_Y, P_TILE, P_ATTR, P_X, P_A0, P_D0, P_A1, P_D1
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_DONE
  } state_t;

  localparam logic [1:0] BYTE_Y    = 2'd0;
  localparam logic [1:0] BYTE_TILE = 2'd1;
  localparam logic [1:0] BYTE_ATTR = 2'd2;
  localparam logic [1:0] BYTE_X    = 2'd3;

  localparam int LD_ATTR   = 0;
  localparam int LD_X      = 1;
  localparam int LD_PLANE1 = 2;
  localparam int LD_PLANE0 = 3;

  localparam logic [7:0] DUMMY_TILE = 8'hFF;

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sprite_pattern_addr.sv
// sprite_pattern_addr: pattern-table address and pixel-byte orientation for one sprite row.
// Purely combinational so the background fetch path can share it.
module sprite_pattern_addr
  import sprite_fetch_pkg::*;
(
  input  logic        obj_size,
  input  logic        obj_patt,
  input  logic [7:0]  tile,
  input  logic [3:0]  row,
  input  logic        flip_x,
  input  logic        flip_y,
  input  logic        dummy,
  input  logic        plane,
  input  logic [7:0]  vram_data,
  output logic [12:0] addr,
  output logic [7:0]  pix
);

  logic [3:0] rf;

  always_comb begin
    rf   = row ^ {4{flip_y}};
    // 8x16 sprites take the table from tile[0] and the tile half from the row's top bit
    addr = {obj_size ? tile[0] : obj_patt, tile[7:1], obj_size ? rf[3] : tile[0], plane, rf[2:0]};
    if (dummy)
      pix = '0;
    else if (flip_x)
      pix = vram_data;
    else
      pix = bit_rev8(vram_data);
  end

endmodule

// File: rtl/sprite_fetch_seq.sv
// sprite_fetch_seq: per-scanline burst fetching pattern bytes for every secondary-OAM slot.
// Build option SPRITE_FETCH_DUMMY_FF_EN: unused slots fetch tile $FF so A12 watchers see real traffic.
module sprite_fetch_seq
  import sprite_fetch_pkg::*;
#(
  parameter  int NUM_SPRITES = 8,
  localparam int IDX_W = $clog2(NUM_SPRITES),
  localparam int CNT_W = $clog2(NUM_SPRITES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             start,
  input  logic             enabled,
  input  logic             obj_size,
  input  logic             obj_patt,
  input  logic [CNT_W-1:0] sprite_count,
  output logic [IDX_W+1:0] temp_addr,
  input  logic [7:0]       temp_data,
  output logic [12:0]      vram_addr,
  output logic             vram_rd,
  input  logic [7:0]       vram_data,
  output logic [3:0]       load,
  output logic [IDX_W-1:0] load_idx,
  output logic [18:0]      load_in,
  output logic             busy,
  output logic             done
);

`ifdef SPRITE_FETCH_DUMMY_FF_EN
  localparam logic DUMMY_FF = 1'b1;
`else
  localparam logic DUMMY_FF = 1'b0;
`endif

  state_t           state_reg, state_next;
  phase_t           phase_reg;
  logic [IDX_W-1:0] slot_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_sat;
  logic [3:0]       row_reg;
  logic [7:0]       tile_reg;
  logic             flip_x_reg, flip_y_reg, dummy_reg;
  logic [12:0]      addr_hold_reg, addr_calc;
  logic [7:0]       pix;
  logic [2:0]       phase_bits;
  logic [1:0]       byte_sel;
  logic             slot_real, force_ff, last_slot, fetch_phase, fetch_en;

  assign phase_bits = phase_reg;
  assign cnt_sat    = (sprite_count > CNT_W'(NUM_SPRITES)) ? CNT_W'(NUM_SPRITES) : sprite_count;
  assign slot_real  = CNT_W'(slot_reg) < cnt_reg;
  assign force_ff   = DUMMY_FF & ~slot_real;
  assign last_slot  = slot_reg == IDX_W'(NUM_SPRITES - 1);

  sprite_pattern_addr u_addr (
    .obj_size  (obj_size),
    .obj_patt  (obj_patt),
    .tile      (tile_reg),
    .row       (row_reg),
    .flip_x    (flip_x_reg),
    .flip_y    (flip_y_reg),
    .dummy     (dummy_reg),
    .plane     (phase_bits[1]),
    .vram_data (vram_data),
    .addr      (addr_calc),
    .pix       (pix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      phase_reg     <= P_Y;
      slot_reg      <= '0;
      cnt_reg       <= '0;
      row_reg       <= '0;
      tile_reg      <= '0;
      flip_x_reg    <= 1'b0;
      flip_y_reg    <= 1'b0;
      dummy_reg     <= 1'b0;
      addr_hold_reg <= '0;
    end else if (ce) begin
      state_reg     <= state_next;
      addr_hold_reg <= vram_addr;
      case (state_reg)
        S_IDLE: if (start) begin
          cnt_reg   <= cnt_sat;
          slot_reg  <= '0;
          phase_reg <= P_Y;
        end
        S_FETCH: begin
          // phase and slot both wrap to zero after the last slot
          phase_reg <= phase_t'(phase_bits + 3'd1);
          if (phase_reg == P_D1) slot_reg <= slot_reg + IDX_W'(1);
          case (phase_reg)
            P_Y:    row_reg  <= force_ff ? 4'd0 : temp_data[3:0];
            P_TILE: tile_reg <= force_ff ? DUMMY_TILE : temp_data;
            P_ATTR: begin
              flip_y_reg <= ~force_ff & temp_data[7];
              flip_x_reg <= ~force_ff & temp_data[6];
              dummy_reg  <= temp_data[4] | ~slot_real;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: if (phase_reg == P_D1 && last_slot) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = state_reg != S_IDLE;
    done        = state_reg == S_DONE;
    fetch_phase = (state_reg == S_FETCH) && (phase_reg == P_A0 || phase_reg == P_A1);
    fetch_en    = fetch_phase && (slot_real || DUMMY_FF);
    vram_rd     = fetch_en;
    // the address only moves on a real fetch; otherwise it holds the last one
    vram_addr   = fetch_en ? addr_calc : addr_hold_reg;
    case (phase_reg)
      P_Y:     byte_sel = BYTE_Y;
      P_TILE:  byte_sel = BYTE_TILE;
      P_ATTR:  byte_sel = BYTE_ATTR;
      default: byte_sel = BYTE_X;
    endcase
    temp_addr = {slot_reg, byte_sel};
    load_idx  = slot_reg;
    load_in   = {pix, temp_data, temp_data[1:0], temp_data[5]};
    load      = '0;
    if (ce && enabled && state_reg == S_FETCH) begin
      case (phase_reg)
        P_ATTR:  load[LD_ATTR]   = 1'b1;
        P_X:     load[LD_X]      = 1'b1;
        P_D0:    load[LD_PLANE0] = 1'b1;
        P_D1:    load[LD_PLANE1] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_seq.sv
// tb_sprite_fetch_seq: directed bench for sprite_fetch_seq with NUM_SPRITES=8,
// hand-computed pattern addresses, pixel bytes and burst timing.
`timescale 1ns/1ps
module tb_sprite_fetch_seq;

  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        reset, ce, start, enabled, obj_size, obj_patt;
  logic [3:0]  sprite_count;
  logic [4:0]  temp_addr;
  logic [7:0]  temp_data;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [3:0]  load;
  logic [2:0]  load_idx;
  logic [18:0] load_in;
  logic        busy, done;

  logic [7:0]  temp_mem [0:4*NS-1];
  assign temp_data = temp_mem[temp_addr];

  always #5 clk = ~clk;

  sprite_fetch_seq #(.NUM_SPRITES(NS)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .enabled(enabled),
    .obj_size(obj_size), .obj_patt(obj_patt), .sprite_count(sprite_count),
    .temp_addr(temp_addr), .temp_data(temp_data), .vram_addr(vram_addr),
    .vram_rd(vram_rd), .vram_data(vram_data), .load(load), .load_idx(load_idx),
    .load_in(load_in), .busy(busy), .done(done)
  );

  int compared, mismatched;
  int n_rec, n_cyc, done_ce, ce0_loads, timed_out;
  logic busy_after;
  logic [12:0] rec_addr [0:127];
  logic        rec_rd   [0:127];
  logic [3:0]  rec_load [0:127];
  logic [2:0]  rec_idx  [0:127];
  logic [18:0] rec_in   [0:127];
  logic [4:0]  rec_ta   [0:127];

  task automatic fill_temp(input logic [7:0] y, input logic [7:0] tile, input logic [7:0] attr);
    for (int s = 0; s < NS; s++) begin
      temp_mem[4*s]   = y;
      temp_mem[4*s+1] = tile;
      temp_mem[4*s+2] = attr;
      temp_mem[4*s+3] = 8'(s*8 + 1);
    end
  endtask

  // Issues start and records every ce-qualified FETCH cycle until the done pulse ends.
  task automatic run_burst(input bit toggle, input bit hold_start);
    int j;
    n_rec = 0; ce0_loads = 0; done_ce = 0; timed_out = 0;
    @(posedge clk); #1; ce = 1'b1; start = 1'b1;
    j = 0;
    forever begin
      @(posedge clk); #1; j++;
      ce = toggle ? (j % 2 == 0) : 1'b1;
      start = hold_start;
      #1;
      if (done || j >= 1000) break;
      if (busy && ce && n_rec < 128) begin
        rec_addr[n_rec] = vram_addr; rec_rd[n_rec] = vram_rd; rec_load[n_rec] = load;
        rec_idx[n_rec] = load_idx; rec_in[n_rec] = load_in; rec_ta[n_rec] = temp_addr;
        n_rec++;
      end else if (busy && !ce && load != 4'b0000) ce0_loads++;
    end
    n_cyc = j;
    start = 1'b0;
    while (done && j < 1000) begin
      if (ce) done_ce++;
      @(posedge clk); #1; j++;
      ce = toggle ? (j % 2 == 0) : 1'b1;
      #1;
    end
    if (j >= 1000) timed_out = 1;
    busy_after = busy;
    ce = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ce = 1'b0; start = 1'b0; enabled = 1'b1; obj_size = 1'b0; obj_patt = 1'b1;
    sprite_count = 4'd8; vram_data = 8'h00; fill_temp(8'h03, 8'h20, 8'h00);
    repeat (3) @(posedge clk);
    #1; ce = 1'b1; #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b exp=0", done); end
    compared++; if (temp_addr !== 5'd0) begin mismatched++; $display("FAIL reset_temp_addr got=%h exp=00", temp_addr); end
    compared++; if (vram_addr !== 13'd0) begin mismatched++; $display("FAIL reset_vram_addr got=%h exp=0000", vram_addr); end
    compared++; if (vram_rd !== 1'b0) begin mismatched++; $display("FAIL reset_vram_rd got=%b exp=0", vram_rd); end
    compared++; if (load !== 4'b0000) begin mismatched++; $display("FAIL reset_load got=%b exp=0000", load); end
    compared++; if (load_idx !== 3'd0) begin mismatched++; $display("FAIL reset_load_idx got=%0d exp=0", load_idx); end
    @(posedge clk); #1; reset = 1'b0;
    $display("reset: outputs checked idle");
  endtask

  task automatic check_timing(input string tag, input int exp_cyc);
    compared++; if (timed_out !== 0) begin mismatched++; $display("FAIL %s_timeout got=%0d exp=0", tag, timed_out); end
    compared++; if (n_rec !== 64) begin mismatched++; $display("FAIL %s_fetch_cycles got=%0d exp=64", tag, n_rec); end
    compared++; if (n_cyc !== exp_cyc) begin mismatched++; $display("FAIL %s_done_cycle got=%0d exp=%0d", tag, n_cyc, exp_cyc); end
    compared++; if (done_ce !== 1) begin mismatched++; $display("FAIL %s_done_width got=%0d exp=1", tag, done_ce); end
    compared++; if (busy_after !== 1'b0) begin mismatched++; $display("FAIL %s_busy_after got=%b exp=0", tag, busy_after); end
  endtask

  task automatic test_basic;
    fill_temp(8'h03, 8'h20, 8'h00);
    enabled = 1'b1; obj_size = 1'b0; obj_patt = 1'b1; sprite_count = 4'd8; vram_data = 8'h01;
    run_burst(1'b0, 1'b0);
    check_timing("basic", 65);
    for (int k = 0; k < 64 && k < n_rec; k++) begin
      int s, p;
      logic [3:0] el;
      logic [7:0] xb;
      s = k / 8; p = k % 8;
      el = (p == 2) ? 4'b0001 : (p == 3) ? 4'b0010 : (p == 5) ? 4'b1000 : (p == 7) ? 4'b0100 : 4'b0000;
      compared++; if (rec_load[k] !== el) begin mismatched++; $display("FAIL basic_load k=%0d got=%b exp=%b", k, rec_load[k], el); end
      compared++; if (rec_rd[k] !== (p == 4 || p == 6)) begin mismatched++; $display("FAIL basic_rd k=%0d got=%b", k, rec_rd[k]); end
      compared++; if (rec_idx[k] !== 3'(s)) begin mismatched++; $display("FAIL basic_idx k=%0d got=%0d exp=%0d", k, rec_idx[k], s); end
      if (p < 4) begin
        compared++; if (rec_ta[k] !== {3'(s), 2'(p)}) begin mismatched++; $display("FAIL basic_temp_addr k=%0d got=%h", k, rec_ta[k]); end
      end
      if (p == 4) begin
        compared++; if (rec_addr[k] !== 13'h1203) begin mismatched++; $display("FAIL basic_addr_p4 k=%0d got=%h exp=1203", k, rec_addr[k]); end
      end
      if (p == 6) begin
        compared++; if (rec_addr[k] !== 13'h120B) begin mismatched++; $display("FAIL basic_addr_p6 k=%0d got=%h exp=120B", k, rec_addr[k]); end
      end
      if (p == 3) begin
        xb = 8'(s*8 + 1);
        compared++; if (rec_in[k][10:0] !== {xb, xb[1:0], xb[5]}) begin mismatched++; $display("FAIL basic_x_in k=%0d got=%h", k, rec_in[k][10:0]); end
      end
      if (p == 5 || p == 7) begin
        compared++; if (rec_in[k][18:11] !== 8'h80) begin mismatched++; $display("FAIL basic_pix k=%0d got=%h exp=80", k, rec_in[k][18:11]); end
      end
    end
    $display("basic: burst of %0d fetch cycles, done at cycle %0d", n_rec, n_cyc);
  endtask

  task automatic test_flip;
    fill_temp(8'h03, 8'h20, 8'h00);
    temp_mem[8] = 8'h01; temp_mem[9] = 8'h35; temp_mem[10] = 8'hC0;
    temp_mem[22] = 8'h10;  // slot 5: attribute dummy bit
    enabled = 1'b1; obj_size = 1'b1; obj_patt = 1'b0; sprite_count = 4'd8; vram_data = 8'h01;
    run_burst(1'b0, 1'b0);
    check_timing("flip", 65);
    compared++; if (rec_addr[20] !== 13'h1356) begin mismatched++; $display("FAIL flip_addr_p4 got=%h exp=1356", rec_addr[20]); end
    compared++; if (rec_addr[22] !== 13'h135E) begin mismatched++; $display("FAIL flip_addr_p6 got=%h exp=135E", rec_addr[22]); end
    compared++; if (rec_in[21][18:11] !== 8'h01) begin mismatched++; $display("FAIL flip_pix got=%h exp=01", rec_in[21][18:11]); end
    compared++; if (rec_in[18][10:0] !== 11'h600) begin mismatched++; $display("FAIL flip_attr_in got=%h exp=600", rec_in[18][10:0]); end
    compared++; if (rec_in[13][18:11] !== 8'h80) begin mismatched++; $display("FAIL flip_noflip_pix got=%h exp=80", rec_in[13][18:11]); end
    compared++; if (rec_in[45][18:11] !== 8'h00) begin mismatched++; $display("FAIL flip_attr_dummy_pix got=%h exp=00", rec_in[45][18:11]); end
    compared++; if (rec_rd[44] !== 1'b1) begin mismatched++; $display("FAIL flip_attr_dummy_rd got=%b exp=1", rec_rd[44]); end
    $display("flip: slot2 p4 addr %h pix %h", rec_addr[20], rec_in[21][18:11]);
  endtask

  task automatic test_dummy;
    fill_temp(8'h03, 8'h20, 8'h00);
    for (int s = 3; s < NS; s++) begin
      temp_mem[4*s] = 8'h05; temp_mem[4*s+1] = 8'h77; temp_mem[4*s+2] = 8'h80;
    end
    enabled = 1'b1; obj_size = 1'b0; obj_patt = 1'b0; sprite_count = 4'd3; vram_data = 8'hFF;
    run_burst(1'b0, 1'b0);
    check_timing("dummy", 65);
    compared++; if (rec_addr[20] !== 13'h0203) begin mismatched++; $display("FAIL dummy_real_addr got=%h exp=0203", rec_addr[20]); end
    compared++; if (rec_in[21][18:11] !== 8'hFF) begin mismatched++; $display("FAIL dummy_real_pix got=%h exp=FF", rec_in[21][18:11]); end
    for (int s = 3; s < NS; s++) begin
      compared++; if (rec_in[8*s+5][18:11] !== 8'h00) begin mismatched++; $display("FAIL dummy_pix0 slot=%0d got=%h exp=00", s, rec_in[8*s+5][18:11]); end
      compared++; if (rec_load[8*s+7] !== 4'b0100) begin mismatched++; $display("FAIL dummy_load1 slot=%0d got=%b exp=0100", s, rec_load[8*s+7]); end
`ifdef SPRITE_FETCH_DUMMY_FF_EN
      compared++; if (rec_addr[8*s+4] !== 13'h0FF0) begin mismatched++; $display("FAIL dummy_ff_addr slot=%0d got=%h exp=0FF0", s, rec_addr[8*s+4]); end
      compared++; if (rec_addr[8*s+6] !== 13'h0FF8) begin mismatched++; $display("FAIL dummy_ff_addr1 slot=%0d got=%h exp=0FF8", s, rec_addr[8*s+6]); end
      compared++; if (rec_rd[8*s+4] !== 1'b1) begin mismatched++; $display("FAIL dummy_ff_rd slot=%0d got=%b exp=1", s, rec_rd[8*s+4]); end
`else
      compared++; if (rec_addr[8*s+4] !== 13'h020B) begin mismatched++; $display("FAIL dummy_hold_addr slot=%0d got=%h exp=020B", s, rec_addr[8*s+4]); end
      compared++; if (rec_rd[8*s+4] !== 1'b0) begin mismatched++; $display("FAIL dummy_rd slot=%0d got=%b exp=0", s, rec_rd[8*s+4]); end
      compared++; if (rec_rd[8*s+6] !== 1'b0) begin mismatched++; $display("FAIL dummy_rd1 slot=%0d got=%b exp=0", s, rec_rd[8*s+6]); end
`endif
    end
    $display("dummy: cnt=3, slot3 p4 addr %h rd %b", rec_addr[28], rec_rd[28]);
  endtask

  task automatic test_disabled;
    fill_temp(8'h03, 8'h20, 8'h00);
    enabled = 1'b0; obj_size = 1'b0; obj_patt = 1'b1; sprite_count = 4'd8; vram_data = 8'h01;
    run_burst(1'b0, 1'b0);
    check_timing("disabled", 65);
    for (int k = 0; k < 64 && k < n_rec; k++) begin
      compared++; if (rec_load[k] !== 4'b0000) begin mismatched++; $display("FAIL disabled_load k=%0d got=%b exp=0000", k, rec_load[k]); end
      if (k % 8 == 4) begin
        compared++; if (rec_addr[k] !== 13'h1203) begin mismatched++; $display("FAIL disabled_addr k=%0d got=%h exp=1203", k, rec_addr[k]); end
      end
      if (k % 8 == 6) begin
        compared++; if (rec_addr[k] !== 13'h120B) begin mismatched++; $display("FAIL disabled_addr1 k=%0d got=%h exp=120B", k, rec_addr[k]); end
      end
    end
    enabled = 1'b1;
    $display("disabled: %0d fetch cycles with load held low", n_rec);
  endtask

  task automatic test_ce_toggle;
    fill_temp(8'h03, 8'h20, 8'h00);
    enabled = 1'b1; obj_size = 1'b0; obj_patt = 1'b1; sprite_count = 4'd8; vram_data = 8'h01;
    run_burst(1'b1, 1'b0);
    check_timing("ce_toggle", 129);
    compared++; if (ce0_loads !== 0) begin mismatched++; $display("FAIL ce_toggle_load_ce0 got=%0d exp=0", ce0_loads); end
    for (int k = 0; k < 64 && k < n_rec; k++) begin
      logic [3:0] el;
      el = (k % 8 == 2) ? 4'b0001 : (k % 8 == 3) ? 4'b0010 : (k % 8 == 5) ? 4'b1000 : (k % 8 == 7) ? 4'b0100 : 4'b0000;
      compared++; if (rec_load[k] !== el) begin mismatched++; $display("FAIL ce_toggle_load k=%0d got=%b exp=%b", k, rec_load[k], el); end
      compared++; if (rec_idx[k] !== 3'(k / 8)) begin mismatched++; $display("FAIL ce_toggle_idx k=%0d got=%0d exp=%0d", k, rec_idx[k], k / 8); end
    end
    $display("ce_toggle: done at cycle %0d", n_cyc);
  endtask

  task automatic test_back_to_back;
    fill_temp(8'h03, 8'h20, 8'h00);
    enabled = 1'b1; obj_size = 1'b0; obj_patt = 1'b1; sprite_count = 4'd12; vram_data = 8'h01;
    for (int b = 0; b < 2; b++) begin
      run_burst(1'b0, 1'b1);
      check_timing("back_to_back", 65);
      compared++; if (rec_rd[60] !== 1'b1) begin mismatched++; $display("FAIL back_to_back_sat_rd burst=%0d got=%b exp=1", b, rec_rd[60]); end
      compared++; if (rec_in[61][18:11] !== 8'h80) begin mismatched++; $display("FAIL back_to_back_sat_pix burst=%0d got=%h exp=80", b, rec_in[61][18:11]); end
      $display("back_to_back: burst %0d done at cycle %0d", b, n_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int done_seen, j;
    fill_temp(8'h03, 8'h20, 8'h00);
    enabled = 1'b1; obj_size = 1'b0; obj_patt = 1'b1; sprite_count = 4'd8; vram_data = 8'h01;
    @(posedge clk); #1; ce = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    compared++; if (load_idx !== 3'd4) begin mismatched++; $display("FAIL reset_mid_slot got=%0d exp=4", load_idx); end
    compared++; if (load !== 4'b1000) begin mismatched++; $display("FAIL reset_mid_p5_load got=%b exp=1000", load); end
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
    compared++; if (load !== 4'b0000) begin mismatched++; $display("FAIL reset_mid_load got=%b exp=0000", load); end
    compared++; if (vram_rd !== 1'b0) begin mismatched++; $display("FAIL reset_mid_rd got=%b exp=0", vram_rd); end
    done_seen = 0;
    repeat (80) begin
      @(posedge clk); #2;
      if (done) done_seen++;
    end
    compared++; if (done_seen !== 0) begin mismatched++; $display("FAIL reset_mid_done got=%0d exp=0", done_seen); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_busy got=%b exp=1", busy); end
    compared++; if (load_idx !== 3'd0) begin mismatched++; $display("FAIL restart_slot got=%0d exp=0", load_idx); end
    compared++; if (temp_addr !== 5'd0) begin mismatched++; $display("FAIL restart_temp_addr got=%h exp=00", temp_addr); end
    j = 0;
    while (busy && j < 200) begin @(posedge clk); #2; j++; end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL restart_timeout busy=%b exp=0", busy); end
    $display("reset_mid: aborted at slot 4 p5, restarted, finished after %0d cycles", j);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    test_reset();
    test_basic();
    test_flip();
    test_dummy();
    test_disabled();
    test_ce_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
